// File: rtl/hdmi_chk_pkg.sv
// Shared types and helpers for the HDMI timing checker: FSM state encoding,
// error flag bit positions, counter type and CRC-16-CCITT step function.
package hdmi_chk_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int ERR_W        = 5;
  localparam int ERR_H_TOTAL  = 0;
  localparam int ERR_H_ACTIVE = 1;
  localparam int ERR_V_ACTIVE = 2;
  localparam int ERR_V_TOTAL  = 3;
  localparam int ERR_DE_SYNC  = 4;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Counters stick at all-ones instead of wrapping so a stalled stream
  // still reads as "too long" rather than aliasing to a legal value.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  // One bit of CRC-16-CCITT, MSB-first shift register form.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return fb ? ({crc[14:0], 1'b0} ^ CRC_POLY) : {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/hdmi_sync_edge.sv
// Input stage: normalises sync polarity, registers the pixel interface once
// and derives leading-edge (hsync/vsync) and falling-edge (DE) pulses.
module hdmi_sync_edge #(
  parameter int DATA_W   = 16,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              pixel_clk_i,
  input  logic              rst_ni,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hs_edge_o,
  output logic              vs_edge_o,
  output logic              de_fall_o
);

  logic              hs_q, vs_q, de_q;
  logic              hs_prev_q, vs_prev_q, de_prev_q;
  logic [DATA_W-1:0] data_q;
  logic              hs_d, vs_d;

  assign hs_d = SYNC_POL ? hsync_i : ~hsync_i;
  assign vs_d = SYNC_POL ? vsync_i : ~vsync_i;

  // Capture stage plus one-cycle history for edge detection.
  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      data_q    <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      de_prev_q <= 1'b0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_i;
      data_q    <= data_i;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      de_prev_q <= de_q;
    end
  end

  assign hs_o      = hs_q;
  assign vs_o      = vs_q;
  assign de_o      = de_q;
  assign data_o    = data_q;
  assign hs_edge_o = hs_q & ~hs_prev_q;
  assign vs_edge_o = vs_q & ~vs_prev_q;
  assign de_fall_o = ~de_q & de_prev_q;

endmodule

// File: rtl/hdmi_timing_checker.sv
// HDMI timing checker top: line/frame geometry counters, sticky error flags,
// lock FSM, frame counter and (with HDMI_CRC_EN defined) per-frame CRC of
// active pixels. Without HDMI_CRC_EN, crc_o is tied to zero.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_SEARCH  | waiting for the first vsync edge, no checks reported
//   ST_MEASURE | checking frames, counting consecutive clean ones
//   ST_LOCKED  | LOCK_FRAMES clean frames seen; any error drops to MEASURE
module hdmi_timing_checker
  import hdmi_chk_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int H_TOTAL     = 2200,
  parameter int H_ACTIVE    = 1920,
  parameter int V_TOTAL     = 1125,
  parameter int V_ACTIVE    = 1080,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              pixel_clk_i,
  input  logic              rst_ni,
  input  logic              hsync_i,
  input  logic              vsync_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_i,
  output logic              locked_o,
  output logic [ERR_W-1:0]  err_o,
  output logic              frame_done_o,
  output logic [15:0]       frame_cnt_o,
  output logic [15:0]       crc_o
);

  localparam cnt_t       H_TOT  = cnt_t'(H_TOTAL);
  localparam cnt_t       H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t       V_TOT  = cnt_t'(V_TOTAL);
  localparam cnt_t       V_ACT  = cnt_t'(V_ACTIVE);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  logic              hs, vs, de, hs_edge, vs_edge, de_fall;
  logic [DATA_W-1:0] data;

  hdmi_sync_edge #(.DATA_W(DATA_W), .SYNC_POL(SYNC_POL)) u_sync_edge (
    .pixel_clk_i(pixel_clk_i), .rst_ni(rst_ni),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .data_i(data_i),
    .hs_o(hs), .vs_o(vs), .de_o(de), .data_o(data),
    .hs_edge_o(hs_edge), .vs_edge_o(vs_edge), .de_fall_o(de_fall)
  );

  cnt_t h_cnt_q, h_cnt_d, de_run_q, de_run_d;
  cnt_t line_cnt_q, line_cnt_d, act_cnt_q, act_cnt_d;
  cnt_t line_upd, act_upd;

  // Geometry counters. An hsync edge coinciding with a vsync edge is folded
  // into line_upd first so the frame check sees the completed line count.
  always_comb begin
    h_cnt_d    = hs_edge ? cnt_t'(1) : sat_inc(h_cnt_q);
    de_run_d   = de ? sat_inc(de_run_q) : '0;
    line_upd   = hs_edge ? sat_inc(line_cnt_q) : line_cnt_q;
    act_upd    = de_fall ? sat_inc(act_cnt_q) : act_cnt_q;
    line_cnt_d = vs_edge ? '0 : line_upd;
    act_cnt_d  = vs_edge ? '0 : act_upd;
  end

  state_e           state_q, state_d;
  logic             h_skip_q, h_skip_d;
  logic [ERR_W-1:0] det;
  logic             err_any;

  // Error detection; the first line period after SEARCH has no valid start.
  always_comb begin
    det = '0;
    if (state_q != ST_SEARCH) begin
      det[ERR_H_TOTAL]  = hs_edge && !h_skip_q && (h_cnt_q != H_TOT);
      det[ERR_H_ACTIVE] = de_fall && (de_run_q != H_ACT);
      det[ERR_V_ACTIVE] = vs_edge && (act_upd != V_ACT);
      det[ERR_V_TOTAL]  = vs_edge && (line_upd != V_TOT);
      det[ERR_DE_SYNC]  = de && (hs || vs);
    end
    h_skip_d = (state_q == ST_SEARCH) ? 1'b1 : (hs_edge ? 1'b0 : h_skip_q);
  end

  assign err_any = |det;

  logic [7:0] clean_q, clean_d;
  logic       frame_err_q, frame_err_d;
  logic       frame_clean;

  assign frame_clean = !(frame_err_q || err_any);

  // Lock FSM next state. frame_err tracks whether the frame ending at the
  // next vsync edge has seen any error.
  always_comb begin
    state_d     = state_q;
    clean_d     = clean_q;
    frame_err_d = vs_edge ? 1'b0 : (frame_err_q | err_any);
    case (state_q)
      ST_SEARCH: begin
        clean_d     = '0;
        frame_err_d = 1'b0;
        if (vs_edge) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (err_any) begin
          clean_d = '0;
        end else if (vs_edge && frame_clean) begin
          clean_d = clean_q + 8'd1;
          if (clean_q + 8'd1 >= LOCK_N) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (err_any) begin
          state_d = ST_MEASURE;
          clean_d = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  logic [ERR_W-1:0] err_q;
  logic             done_q;
  logic [15:0]      frame_cnt_q;

  // State, counters and reported outputs; a new error beats a same-cycle clear.
  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_SEARCH;
      h_skip_q    <= 1'b1;
      clean_q     <= '0;
      frame_err_q <= 1'b0;
      h_cnt_q     <= '0;
      de_run_q    <= '0;
      line_cnt_q  <= '0;
      act_cnt_q   <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_skip_q    <= h_skip_d;
      clean_q     <= clean_d;
      frame_err_q <= frame_err_d;
      h_cnt_q     <= h_cnt_d;
      de_run_q    <= de_run_d;
      line_cnt_q  <= line_cnt_d;
      act_cnt_q   <= act_cnt_d;
      err_q       <= (clr_i ? '0 : err_q) | det;
      done_q      <= vs_edge && (state_q != ST_SEARCH);
      if (vs_edge && (state_q != ST_SEARCH)) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign locked_o     = (state_q == ST_LOCKED);
  assign err_o        = err_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = frame_cnt_q;

`ifdef HDMI_CRC_EN
  logic [15:0] crc_run_q, crc_run_d, crc_q;

  // Running CRC over active pixels, reseeded at every frame start.
  always_comb begin
    crc_run_d = crc_run_q;
    if (vs_edge) begin
      crc_run_d = CRC_INIT;
    end else if (de) begin
      for (int i = DATA_W - 1; i >= 0; i--) crc_run_d = crc16_step(crc_run_d, data[i]);
    end
  end

  // Completed-frame CRC is published alongside frame_done_o.
  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_run_q <= CRC_INIT;
      crc_q     <= '0;
    end else begin
      crc_run_q <= crc_run_d;
      if (vs_edge && (state_q != ST_SEARCH)) crc_q <= crc_run_q;
    end
  end

  assign crc_o = crc_q;
`else
  logic unused_data;
  assign unused_data = ^data;
  assign crc_o       = '0;
`endif

endmodule
